// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder around one 4-bit carry-lookahead slice.
// Optional signed-overflow flag port: define CLA_OVF_FLAG_EN.

module four_bit_carry_lookahead_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c[0] = cin;
    c[1] = g[0]
         | (p[0] & cin);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    cout = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign s = p ^ c;

endmodule

module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CLA_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic       accept;
  logic       step;
  logic       last;
  logic [3:0] sl_s;
  logic       sl_cout;

  assign last = (cnt_q == CW'(NIBBLES - 1));

  // Operand regs shift right each pass, so the active nibble is always [3:0]
  four_bit_carry_lookahead_adder u_slice (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = ADD;
      ADD:  if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      ADD: begin
        busy = 1'b1;
        step = 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          a_q     <= a;
          b_q     <= b;
          carry_q <= cin;
          cnt_q   <= '0;
        end
        step: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= sl_cout;
          for (int k = 0; k < NIBBLES; k++) begin
            if (cnt_q == CW'(k)) sum[4*k +: 4] <= sl_s;
          end
          if (last) begin
            cout  <= sl_cout;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CLA_OVF_FLAG_EN
  // On the final pass a_q[3]/b_q[3] are the operand sign bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (step && last) begin
      ovf <= (a_q[3] == b_q[3]) && (sl_s[3] != a_q[3]);
    end
  end
`endif

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed bench for cla_nibble_serial_adder, WIDTH=16 and WIDTH=4 instances.
// Define CLA_OVF_FLAG_EN to also check the overflow flag.

module tb_cla_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        iv16 = 1'b0;
  logic        ir16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        ci16 = 1'b0;
  logic        ov16;
  logic        or16 = 1'b0;
  logic [15:0] s16;
  logic        co16;
  logic        bz16;

  logic       iv4 = 1'b0;
  logic       ir4;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       ci4 = 1'b0;
  logic       ov4;
  logic       or4 = 1'b0;
  logic [3:0] s4;
  logic       co4;
  logic       bz4;

`ifdef CLA_OVF_FLAG_EN
  logic of16;
  logic of4;
`endif

  int nchk = 0;
  int nfail = 0;
  int lat;

  always #5 clk = ~clk;

  cla_nibble_serial_adder #(.WIDTH(16)) u16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (a16),
    .b         (b16),
    .cin       (ci16),
    .out_valid (ov16),
    .out_ready (or16),
    .sum       (s16),
    .cout      (co16),
`ifdef CLA_OVF_FLAG_EN
    .ovf       (of16),
`endif
    .busy      (bz16)
  );

  cla_nibble_serial_adder #(.WIDTH(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .a         (a4),
    .b         (b4),
    .cin       (ci4),
    .out_valid (ov4),
    .out_ready (or4),
    .sum       (s4),
    .cout      (co4),
`ifdef CLA_OVF_FLAG_EN
    .ovf       (of4),
`endif
    .busy      (bz4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one op, scramble operands after the accepting edge,
  // then count cycles until out_valid (bounded).
  task automatic run16(input logic [15:0] ta, input logic [15:0] tb,
                       input logic tc, output int n);
    a16 = ta;
    b16 = tb;
    ci16 = tc;
    iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    a16 = 16'hDEAD;
    b16 = 16'hBEEF;
    ci16 = ~tc;
    n = 0;
    while (!ov16 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain16;
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sum", 32'(s16), 32'h0);
    chk("rst_ov", 32'(ov16), 32'h0);
    chk("rst_busy", 32'(bz16), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(ir16), 32'h1);
    chk("rel_cout", 32'(co16), 32'h0);
`ifdef CLA_OVF_FLAG_EN
    chk("rst_ovf", 32'(of16), 32'h0);
`endif

    // 1234 + 4321
    run16(16'h1234, 16'h4321, 1'b0, lat);
    chk("t1_lat", 32'(lat), 32'd4);
    chk("t1_sum", 32'(s16), 32'h5555);
    chk("t1_cout", 32'(co16), 32'h0);
    chk("t1_busy", 32'(bz16), 32'h1);
    drain16();
    chk("t1_idle", 32'(ir16), 32'h1);

    // full ripple
    run16(16'hFFFF, 16'h0000, 1'b1, lat);
    chk("t2_lat", 32'(lat), 32'd4);
    chk("t2_sum", 32'(s16), 32'h0000);
    chk("t2_cout", 32'(co16), 32'h1);
`ifdef CLA_OVF_FLAG_EN
    chk("t2_ovf", 32'(of16), 32'h0);
`endif
    drain16();

    // positive overflow
    run16(16'h7FFF, 16'h0001, 1'b0, lat);
    chk("t3_sum", 32'(s16), 32'h8000);
    chk("t3_cout", 32'(co16), 32'h0);
`ifdef CLA_OVF_FLAG_EN
    chk("t3_ovf", 32'(of16), 32'h1);
`endif
    drain16();

    // negative overflow with carry out
    run16(16'h8000, 16'h8000, 1'b0, lat);
    chk("t3b_sum", 32'(s16), 32'h0000);
    chk("t3b_cout", 32'(co16), 32'h1);
`ifdef CLA_OVF_FLAG_EN
    chk("t3b_ovf", 32'(of16), 32'h1);
`endif
    drain16();

    // FFFF+FFFF+1, no overflow
    run16(16'hFFFF, 16'hFFFF, 1'b1, lat);
    chk("t3c_sum", 32'(s16), 32'hFFFF);
    chk("t3c_cout", 32'(co16), 32'h1);
`ifdef CLA_OVF_FLAG_EN
    chk("t3c_ovf", 32'(of16), 32'h0);
`endif

    // backpressure in DONE, new request ignored
    for (int i = 0; i < 5; i++) begin
      iv16 = (i == 2);
      a16 = 16'h0101;
      b16 = 16'h0202;
      @(negedge clk);
      chk("t4_hold_sum", 32'(s16), 32'hFFFF);
      chk("t4_hold_ov", 32'(ov16), 32'h1);
      chk("t4_rdy", 32'(ir16), 32'h0);
    end
    iv16 = 1'b0;
    drain16();
    chk("t4_idle_rdy", 32'(ir16), 32'h1);
    chk("t4_idle_ov", 32'(ov16), 32'h0);
    chk("t4_keep_sum", 32'(s16), 32'hFFFF);
    chk("t4_keep_cout", 32'(co16), 32'h1);

    // reset at counter=2
    a16 = 16'hABCD;
    b16 = 16'h1111;
    ci16 = 1'b0;
    iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_pre_sum", 32'(s16[7:0]), 32'hDE);
    rst_n = 1'b0;
    #1;
    chk("t5_sum", 32'(s16), 32'h0);
    chk("t5_cout", 32'(co16), 32'h0);
    chk("t5_busy", 32'(bz16), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rdy", 32'(ir16), 32'h1);
    repeat (6) @(negedge clk);
    chk("t5_no_ov", 32'(ov16), 32'h0);
    run16(16'h0001, 16'h0001, 1'b0, lat);
    chk("t5_lat", 32'(lat), 32'd4);
    chk("t5_next_sum", 32'(s16), 32'h0002);
    chk("t5_next_cout", 32'(co16), 32'h0);
    drain16();

    // WIDTH=4: single ADD cycle
    a4 = 4'hF;
    b4 = 4'h1;
    ci4 = 1'b0;
    iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    chk("w4_acc_busy", 32'(bz4), 32'h1);
    @(negedge clk);
    chk("w4_lat_ov", 32'(ov4), 32'h1);
    chk("w4_sum", 32'(s4), 32'h0);
    chk("w4_cout", 32'(co4), 32'h1);
`ifdef CLA_OVF_FLAG_EN
    chk("w4_ovf", 32'(of4), 32'h0);
`endif
    or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
    chk("w4_idle", 32'(ir4), 32'h1);

    a4 = 4'h7;
    b4 = 4'h1;
    iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    @(negedge clk);
    chk("w4b_sum", 32'(s4), 32'h8);
    chk("w4b_cout", 32'(co4), 32'h0);
`ifdef CLA_OVF_FLAG_EN
    chk("w4b_ovf", 32'(of4), 32'h1);
`endif

    // back-to-back: one op per 3 cycles
    a4 = 4'h3;
    b4 = 4'h4;
    iv4 = 1'b1;
    or4 = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!ov4 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("w4_b2b_first", 32'(ov4), 32'h1);
    chk("w4_b2b_sum", 32'(s4), 32'h7);
    @(negedge clk);
    lat = 1;
    while (!ov4 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("w4_b2b_period", 32'(lat), 32'd3);
    iv4 = 1'b0;
    or4 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
